mem_ctrl: RTL

Block-level controller between the cache miss path and main memory (`mem`). Accepts cache line fills and dirty-line write-backs over a single valid/ready request channel. Buffers write-backs in a small FIFO and drains them to memory in the background. Sequences one block read at a time and returns the line with a one-cycle response pulse. All main-memory traffic in the design passes through this block.

---
 rtl/mem_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - cache-miss memory controller: fill sequencing plus background write-back FIFO
// Define MEM_CTRL_WB_FWD_EN to serve fills from matching queued write-backs instead of flushing first.
`ifndef BYTE
`define BYTE 8
`endif
`ifndef BLK_WIDTH
`define BLK_WIDTH 256
`endif
`ifndef PA_WIDTH
`define PA_WIDTH 20
`endif

module mem_ctrl #(
  parameter int BLK_WIDTH = `BLK_WIDTH,
  parameter int PA_WIDTH  = `PA_WIDTH,
  parameter int WB_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [PA_WIDTH-1:0]  req_addr,
  input  logic [BLK_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BLK_WIDTH-1:0] resp_data,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_data,
  input  logic [BLK_WIDTH-1:0] mem_rd_data
);
  localparam int OFF   = $clog2(BLK_WIDTH / `BYTE);
  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);
  localparam logic [PA_WIDTH-1:0] ALIGN_MASK = {PA_WIDTH{1'b1}} << OFF;
`ifdef MEM_CTRL_WB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, RD, WAIT, RESP} state_e;

  state_e               state_q;
  logic [PA_WIDTH-1:0]  fill_addr_q;
  logic [PA_WIDTH-1:0]  mem_addr_q;
  logic                 mem_rd_en_q, mem_wr_en_q, resp_valid_q;
  logic [BLK_WIDTH-1:0] mem_wr_data_q, resp_data_q;

  logic [PA_WIDTH-1:0]  wb_addr_q [WB_DEPTH];
  logic [BLK_WIDTH-1:0] wb_data_q [WB_DEPTH];
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;

  logic                 wb_full, wb_empty, push, pop, fill_acc;
  logic [PA_WIDTH-1:0]  req_addr_al;
  logic                 fwd_hit;
  logic [BLK_WIDTH-1:0] fwd_data;

  assign wb_full     = (count_q == CNT_W'(WB_DEPTH));
  assign wb_empty    = (count_q == '0);
  assign req_ready   = req_wr ? !wb_full : (state_q == IDLE);
  assign push        = req_valid && req_ready && req_wr;
  assign fill_acc    = req_valid && req_ready && !req_wr;
  assign req_addr_al = req_addr & ALIGN_MASK;

  // Without forwarding, a fill in IDLE pops the head immediately and enters FLUSH.
  assign pop = !wb_empty &&
               (((state_q == IDLE) && (!fill_acc || !FWD_EN)) || (state_q == FLUSH));

`ifdef MEM_CTRL_WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    // Walk oldest to newest so the last match is the newest write.
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_idx = PTR_W'((int'(head_q) + i) % WB_DEPTH);
      if ((i < int'(count_q)) && (wb_addr_q[fwd_idx] == req_addr_al)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[fwd_idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[tail_q] <= req_addr_al;
      wb_data_q[tail_q] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= (tail_q == PTR_W'(WB_DEPTH - 1)) ? '0 : tail_q + 1'b1;
      if (pop)  head_q <= (head_q == PTR_W'(WB_DEPTH - 1)) ? '0 : head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fill_addr_q   <= '0;
      mem_addr_q    <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      if (pop) begin
        mem_wr_en_q   <= 1'b1;
        mem_addr_q    <= wb_addr_q[head_q];
        mem_wr_data_q <= wb_data_q[head_q];
      end
      case (state_q)
        IDLE: begin
          if (fill_acc) begin
            fill_addr_q <= req_addr_al;
            if (fwd_hit) begin
              resp_data_q <= fwd_data;
              state_q     <= RESP;
            end else if (pop) begin
              state_q <= FLUSH;
            end else begin
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= req_addr_al;
              state_q     <= RD;
            end
          end else if (pop) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: state_q <= IDLE;
        FLUSH: begin
          if (!pop) begin
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= fill_addr_q;
            state_q     <= RD;
          end
        end
        RD:   state_q <= WAIT;
        WAIT: begin
          resp_data_q  <= mem_rd_data;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        // A forwarded fill arrives with resp_valid low and raises it one cycle later.
        RESP: begin
          if (resp_valid_q) state_q <= IDLE;
          else              resp_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
endmodule
